keycode_event_encoder: RTL and testbench
========================================

KEYCODE_EVENT_ENCODER -- requirements
Module: keycode_event_encoder

Interface
REQ-001 Parameter WIDTH, default 16, number of one-hot key lines; legal range 2..64.
REQ-002 Parameter CODE_W, default 4, binary code width; SHALL equal ceil(log2(WIDTH)).
REQ-003 Parameter STABLE_CYCLES, default 4, number of consecutive equal samples required to accept a pattern; legal range 1..255.
REQ-004 Parameter FIFO_DEPTH, default 4, event FIFO entries; power of two, at least 2.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 onehot  in  WIDTH  raw key lines, asynchronous to nothing (already synchronous to clk), bit i = key i.
REQ-008 evt_valid  out  1  FIFO not empty.
REQ-009 evt_ready  in  1  consumer accepts head event when evt_valid=1.
REQ-010 evt_code  out  CODE_W  code of head event.
REQ-011 evt_press  out  1  head event type: 1 = press, 0 = release.
REQ-012 code  out  CODE_W  currently held key code; 0 when none held.
REQ-013 code_valid  out  1  a key is currently held.
REQ-014 multi_err  out  1  last accepted pattern was multi-hot.
REQ-015 overflow  out  1  sticky flag: an event was dropped because the FIFO was full.
REQ-016 clr_overflow  in  1  synchronous clear of overflow.

Function
REQ-017 smp SHALL register onehot every edge.
REQ-018 cnt SHALL be cleared to 0 on an edge where onehot != smp; otherwise it increments, saturating at STABLE_CYCLES.
REQ-019 A pattern is accepted on an edge where cnt==STABLE_CYCLES and smp != acc; acc (the last accepted pattern) SHALL then load smp.
REQ-020 Latency: with onehot held constant from before edge 1, the resulting event SHALL be written at edge STABLE_CYCLES+2, with evt_valid=1 immediately after that edge (after edge 6 for the default).
REQ-021 Binary code of a one-hot pattern SHALL be the index of its set bit.
REQ-022 FSM states: IDLE, HELD, SWAP.
REQ-023 IDLE, accepted one-hot j: push press(j), go to HELD, code=j.
REQ-024 HELD k, accepted zero pattern: push release(k), go to IDLE, code=0.
REQ-025 HELD k, accepted one-hot j with j != k: push release(k), go to SWAP.
REQ-026 SWAP: on the next edge, push press(j), go to HELD, code=j; no acceptance SHALL occur in SWAP, and any pending pattern is evaluated after SWAP exits.
REQ-027 Accepted multi-hot pattern: set multi_err=1, leave state and code unchanged, push no event.
REQ-028 Any accepted zero or one-hot pattern SHALL clear multi_err.
REQ-029 Accepted zero pattern in IDLE: no event.
REQ-030 code_valid SHALL be 1 in HELD and SWAP; during SWAP, code SHALL still show k.
REQ-031 The FIFO SHALL be first-word-fall-through, with entries {press, code}; a pop occurs when evt_valid and evt_ready are both 1.
REQ-032 A push SHALL be accepted when the FIFO is not full, or when it is full and a pop occurs on the same edge.
REQ-033 A push that is not accepted SHALL be dropped and set overflow; the FSM still advances.
REQ-034 Simultaneous push and pop on an empty FIFO: the push is stored and evt_valid=1 after the edge; no pop occurs.
REQ-035 clr_overflow and a drop on the same edge: overflow SHALL remain 1 (set wins).
REQ-036 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with a separate full/empty distinction (extra pointer bit or count).

Reset
REQ-037 While rst_n=0, the following SHALL hold: smp=0, cnt=0, acc=0, state IDLE, code=0, code_valid=0, multi_err=0, overflow=0, FIFO empty, evt_valid=0; evt_code and evt_press are don't-care but driven 0.
REQ-038 Reset asserted mid-operation SHALL discard queued events and emit no release for a held key; after release, a still-pressed key is re-detected as a new press.

Verification
REQ-039 Default parameters, onehot=16'h0020 held from before edge 1: evt_valid rises after edge 6 with evt_code=5 and evt_press=1; code=5 and code_valid=1.
REQ-040 Glitch: onehot=16'h0008 for 3 cycles, then 0: no event; cnt never reaches 4; evt_valid stays 0.
REQ-041 Key 2 held, then changed directly to key 9 and held, with evt_ready=1: events release(2) then press(9) on consecutive edges; code goes 2 -> 9.
REQ-042 onehot=16'h0011 held: multi_err=1, no event, code unchanged; then onehot=0 held: multi_err=0.
REQ-043 evt_ready=0 and 5 distinct press/release events: 4 queued, overflow=1; pulse clr_overflow: overflow=0; drain yields the first 4 events in order.
REQ-044 Reset asserted while 2 events are queued and key 7 is held: evt_valid=0 and code_valid=0 immediately; after deassertion with key 7 still held, press(7) appears after edge 6.

Source files
------------

// File: rtl/keycode_event_encoder.sv
// keycode_event_encoder
// Debounces a bank of key lines and turns each accepted change into
// press/release events, queued in a small first-word-fall-through FIFO.
// A direct key-to-key change is reported as release(old) then press(new)
// on consecutive edges via the SWAP state.
module keycode_event_encoder #(
   parameter int WIDTH         = 16,
   parameter int CODE_W        = 4,
   parameter int STABLE_CYCLES = 4,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  onehot,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [CODE_W-1:0] evt_code,
   output logic              evt_press,
   output logic [CODE_W-1:0] code,
   output logic              code_valid,
   output logic              multi_err,
   output logic              overflow,
   input  logic              clr_overflow
);

   localparam int         AW       = $clog2(FIFO_DEPTH);
   localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_SWAP = 2'd2
   } state_t;

   // True when exactly one bit of v is set.
   function automatic logic f_is_onehot(input logic [WIDTH-1:0] v);
      return (v != {WIDTH{1'b0}}) && ((v & (v - WIDTH'(1'b1))) == {WIDTH{1'b0}});
   endfunction

   // Index of the highest set bit; only meaningful for one-hot inputs.
   function automatic logic [CODE_W-1:0] f_encode(input logic [WIDTH-1:0] v);
      logic [CODE_W-1:0] idx;
      idx = {CODE_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            idx = CODE_W'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   // sampler / stability counter
   logic [WIDTH-1:0]  r_smp;
   logic [7:0]        r_cnt;

   // FSM and accepted-pattern state
   state_t            r_state;
   state_t            w_state_nxt;
   logic [WIDTH-1:0]  r_acc;
   logic [WIDTH-1:0]  w_acc_nxt;
   logic [CODE_W-1:0] r_code;
   logic [CODE_W-1:0] w_code_nxt;
   logic [CODE_W-1:0] r_pend;
   logic [CODE_W-1:0] w_pend_nxt;
   logic              r_merr;
   logic              w_merr_nxt;
   logic              r_code_valid;

   // event push request
   logic              w_push;
   logic [CODE_W:0]   w_push_entry;

   // FIFO
   logic [CODE_W:0]   r_mem [FIFO_DEPTH];
   logic [AW:0]       r_wr;
   logic [AW:0]       r_rd;
   logic              r_ovf;
   logic              w_empty;
   logic              w_full;
   logic              w_pop;
   logic              w_push_ok;
   logic              w_drop;
   logic [CODE_W:0]   w_head;

   logic              w_accept;
   logic              w_smp_zero;
   logic              w_smp_onehot;
   logic [CODE_W-1:0] w_smp_code;

   // Sample the key lines and count how long the sample has been unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_smp <= {WIDTH{1'b0}};
         r_cnt <= 8'd0;
      end else begin
         r_smp <= onehot;
         if (onehot != r_smp) begin
            r_cnt <= 8'd0;
         end else if (r_cnt != STABLE_C) begin
            r_cnt <= r_cnt + 8'd1;
         end else begin
            r_cnt <= r_cnt;
         end
      end
   end

   // Acceptance is suppressed in SWAP so the pending press goes out first.
   assign w_accept     = (r_cnt == STABLE_C) && (r_smp != r_acc) && (r_state != ST_SWAP);
   assign w_smp_zero   = (r_smp == {WIDTH{1'b0}});
   assign w_smp_onehot = f_is_onehot(r_smp);
   assign w_smp_code   = f_encode(r_smp);

   // Next-state, held-code and event generation for accepted patterns.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_code_nxt   = r_code;
      w_pend_nxt   = r_pend;
      w_merr_nxt   = r_merr;
      w_push       = 1'b0;
      w_push_entry = {(CODE_W + 1){1'b0}};
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_acc_nxt = r_smp;
               if (w_smp_onehot) begin
                  w_merr_nxt   = 1'b0;
                  w_push       = 1'b1;
                  w_push_entry = {1'b1, w_smp_code};
                  w_code_nxt   = w_smp_code;
                  w_state_nxt  = ST_HELD;
               end else if (w_smp_zero) begin
                  w_merr_nxt = 1'b0;
               end else begin
                  w_merr_nxt = 1'b1;
               end
            end else begin
               w_acc_nxt = r_acc;
            end
         end
         ST_HELD: begin
            if (w_accept) begin
               w_acc_nxt = r_smp;
               if (w_smp_zero) begin
                  w_merr_nxt   = 1'b0;
                  w_push       = 1'b1;
                  w_push_entry = {1'b0, r_code};
                  w_code_nxt   = {CODE_W{1'b0}};
                  w_state_nxt  = ST_IDLE;
               end else if (w_smp_onehot) begin
                  w_merr_nxt = 1'b0;
                  if (w_smp_code != r_code) begin
                     w_push       = 1'b1;
                     w_push_entry = {1'b0, r_code};
                     w_pend_nxt   = w_smp_code;
                     w_state_nxt  = ST_SWAP;
                  end else begin
                     w_state_nxt = ST_HELD;
                  end
               end else begin
                  w_merr_nxt = 1'b1;
               end
            end else begin
               w_acc_nxt = r_acc;
            end
         end
         ST_SWAP: begin
            w_push       = 1'b1;
            w_push_entry = {1'b1, r_pend};
            w_code_nxt   = r_pend;
            w_state_nxt  = ST_HELD;
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_code_nxt  = {CODE_W{1'b0}};
         end
      endcase
   end

   // FSM state register and the values it owns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_acc        <= {WIDTH{1'b0}};
         r_code       <= {CODE_W{1'b0}};
         r_pend       <= {CODE_W{1'b0}};
         r_merr       <= 1'b0;
         r_code_valid <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_acc        <= w_acc_nxt;
         r_code       <= w_code_nxt;
         r_pend       <= w_pend_nxt;
         r_merr       <= w_merr_nxt;
         r_code_valid <= (w_state_nxt != ST_IDLE);
      end
   end

   // A full FIFO still takes a push when the head leaves on the same edge.
   assign w_empty   = (r_wr == r_rd);
   assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
   assign w_pop     = !w_empty && evt_ready;
   assign w_push_ok = w_push && (!w_full || w_pop);
   assign w_drop    = w_push && !w_push_ok;

   // FIFO read/write pointers, one extra bit to tell full from empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr <= {(AW + 1){1'b0}};
         r_rd <= {(AW + 1){1'b0}};
      end else begin
         if (w_push_ok) begin
            r_wr <= r_wr + {{AW{1'b0}}, 1'b1};
         end else begin
            r_wr <= r_wr;
         end
         if (w_pop) begin
            r_rd <= r_rd + {{AW{1'b0}}, 1'b1};
         end else begin
            r_rd <= r_rd;
         end
      end
   end

   // FIFO storage; cleared on reset so stale entries never surface.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= {(CODE_W + 1){1'b0}};
         end
      end else if (w_push_ok) begin
         r_mem[r_wr[AW-1:0]] <= w_push_entry;
      end else begin
         r_mem[r_wr[AW-1:0]] <= r_mem[r_wr[AW-1:0]];
      end
   end

   // Sticky overflow; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ovf <= 1'b0;
      end else if (w_drop) begin
         r_ovf <= 1'b1;
      end else if (clr_overflow) begin
         r_ovf <= 1'b0;
      end else begin
         r_ovf <= r_ovf;
      end
   end

   assign w_head     = r_mem[r_rd[AW-1:0]];
   assign evt_valid  = !w_empty;
   assign evt_code   = w_empty ? {CODE_W{1'b0}} : w_head[CODE_W-1:0];
   assign evt_press  = w_empty ? 1'b0 : w_head[CODE_W];
   assign code       = r_code;
   assign code_valid = r_code_valid;
   assign multi_err  = r_merr;
   assign overflow   = r_ovf;

endmodule

// File: tb/tb_keycode_event_encoder.sv
// Bench for keycode_event_encoder: expected events go into a scoreboard
// queue when a pattern is driven and are checked as the DUT hands them out.
module tb_keycode_event_encoder;

   logic        clk;
   logic        rst_n;
   logic [15:0] onehot;
   logic        evt_valid;
   logic        evt_ready;
   logic [3:0]  evt_code;
   logic        evt_press;
   logic [3:0]  code;
   logic        code_valid;
   logic        multi_err;
   logic        overflow;
   logic        clr_overflow;

   int n_cmp;
   int n_fail;
   logic [4:0] q[$];

   typedef struct {
      logic [15:0] pat;
      logic [3:0]  exp_code;
      logic        exp_cv;
      logic        exp_merr;
      int          n_evt;
      logic [4:0]  e0;
      logic [4:0]  e1;
   } vec_t;

   vec_t vecs[10];

   keycode_event_encoder dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .onehot       (onehot),
      .evt_valid    (evt_valid),
      .evt_ready    (evt_ready),
      .evt_code     (evt_code),
      .evt_press    (evt_press),
      .code         (code),
      .code_valid   (code_valid),
      .multi_err    (multi_err),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   // free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // At the falling edge, any event about to be popped is checked against the queue.
   task automatic mon();
      logic [4:0] e;
      if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL unexpected_evt: got press=%0b code=%0d expected none (t=%0t)",
                     evt_press, evt_code, $time);
         end else begin
            e = q.pop_front();
            chk("evt", {27'd0, evt_press, evt_code}, {27'd0, e});
         end
      end
   endtask

   // Advance n clocks, ending 1 time unit after a rising edge.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         mon();
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;

      //               pat        code  cv    merr  n  e0            e1
      vecs[0] = '{16'h0000, 4'd0,  1'b0, 1'b0, 1, {1'b0, 4'd5},  5'd0};
      vecs[1] = '{16'h0004, 4'd2,  1'b1, 1'b0, 1, {1'b1, 4'd2},  5'd0};
      vecs[2] = '{16'h0200, 4'd9,  1'b1, 1'b0, 2, {1'b0, 4'd2},  {1'b1, 4'd9}};
      vecs[3] = '{16'h0011, 4'd9,  1'b1, 1'b1, 0, 5'd0,          5'd0};
      vecs[4] = '{16'h0000, 4'd0,  1'b0, 1'b0, 1, {1'b0, 4'd9},  5'd0};
      vecs[5] = '{16'h0011, 4'd0,  1'b0, 1'b1, 0, 5'd0,          5'd0};
      vecs[6] = '{16'h0000, 4'd0,  1'b0, 1'b0, 0, 5'd0,          5'd0};
      vecs[7] = '{16'h8000, 4'd15, 1'b1, 1'b0, 1, {1'b1, 4'd15}, 5'd0};
      vecs[8] = '{16'h0001, 4'd0,  1'b1, 1'b0, 2, {1'b0, 4'd15}, {1'b1, 4'd0}};
      vecs[9] = '{16'h0000, 4'd0,  1'b0, 1'b0, 1, {1'b0, 4'd0},  5'd0};

      // ---- reset state, key 5 already pressed ----
      rst_n        = 1'b0;
      onehot       = 16'h0020;
      evt_ready    = 1'b0;
      clr_overflow = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_evt_valid",  {31'd0, evt_valid},  32'd0);
      chk("rst_code",       {28'd0, code},       32'd0);
      chk("rst_code_valid", {31'd0, code_valid}, 32'd0);
      chk("rst_multi_err",  {31'd0, multi_err},  32'd0);
      chk("rst_overflow",   {31'd0, overflow},   32'd0);
      chk("rst_evt_code",   {28'd0, evt_code},   32'd0);
      chk("rst_evt_press",  {31'd0, evt_press},  32'd0);
      tick(1);
      rst_n = 1'b1;

      // ---- first-event latency: press(5) after edge 6 ----
      q.push_back({1'b1, 4'd5});
      tick(5);
      chk("lat_valid_e5", {31'd0, evt_valid}, 32'd0);
      tick(1);
      chk("lat_valid_e6", {31'd0, evt_valid},  32'd1);
      chk("lat_evt_code", {28'd0, evt_code},   32'd5);
      chk("lat_evt_press", {31'd0, evt_press}, 32'd1);
      chk("lat_code",     {28'd0, code},       32'd5);
      chk("lat_code_valid", {31'd0, code_valid}, 32'd1);
      evt_ready = 1'b1;
      tick(2);
      chk("lat_drained", q.size(), 32'd0);

      // ---- table-driven patterns ----
      for (int i = 0; i < 10; i++) begin
         onehot = vecs[i].pat;
         if (vecs[i].n_evt > 0) q.push_back(vecs[i].e0);
         if (vecs[i].n_evt > 1) q.push_back(vecs[i].e1);
         tick(10);
         chk($sformatf("vec%0d_code", i),       {28'd0, code},       {28'd0, vecs[i].exp_code});
         chk($sformatf("vec%0d_code_valid", i), {31'd0, code_valid}, {31'd0, vecs[i].exp_cv});
         chk($sformatf("vec%0d_multi_err", i),  {31'd0, multi_err},  {31'd0, vecs[i].exp_merr});
      end
      chk("vec_queue_empty", q.size(), 32'd0);

      // ---- glitch: key 3 for only 3 cycles ----
      begin
         int seen;
         seen = 0;
         onehot = 16'h0008;
         for (int c = 0; c < 3; c++) begin
            tick(1);
            if (evt_valid === 1'b1) seen++;
         end
         onehot = 16'h0000;
         for (int c = 0; c < 10; c++) begin
            tick(1);
            if (evt_valid === 1'b1) seen++;
         end
         chk("glitch_valid_cycles", seen, 32'd0);
         chk("glitch_code_valid", {31'd0, code_valid}, 32'd0);
      end

      // ---- overflow: five events into a four-deep FIFO ----
      evt_ready = 1'b0;
      begin
         logic [15:0] pats [5];
         logic [4:0]  evs  [5];
         pats[0] = 16'h0002; evs[0] = {1'b1, 4'd1};
         pats[1] = 16'h0000; evs[1] = {1'b0, 4'd1};
         pats[2] = 16'h0008; evs[2] = {1'b1, 4'd3};
         pats[3] = 16'h0000; evs[3] = {1'b0, 4'd3};
         pats[4] = 16'h0010; evs[4] = {1'b1, 4'd4};
         for (int k = 0; k < 5; k++) begin
            onehot = pats[k];
            if (k < 4) q.push_back(evs[k]);
            tick(8);
         end
      end
      chk("ovf_set",       {31'd0, overflow},  32'd1);
      chk("ovf_evt_valid", {31'd0, evt_valid}, 32'd1);
      chk("ovf_code",      {28'd0, code},      32'd4);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;
      chk("ovf_cleared", {31'd0, overflow}, 32'd0);
      // release(4) is dropped on the same edge clr_overflow is high
      clr_overflow = 1'b1;
      onehot = 16'h0000;
      tick(5);
      chk("ovf_before_drop", {31'd0, overflow}, 32'd0);
      tick(1);
      chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
      chk("ovf_fsm_advanced", {31'd0, code_valid}, 32'd0);
      clr_overflow = 1'b0;
      evt_ready = 1'b1;
      tick(8);
      chk("ovf_drained", q.size(), 32'd0);
      chk("ovf_drain_valid", {31'd0, evt_valid}, 32'd0);
      clr_overflow = 1'b1;
      tick(1);
      clr_overflow = 1'b0;

      // ---- reset with two queued events and key 7 held ----
      onehot = 16'h0008;
      q.push_back({1'b1, 4'd3});
      tick(8);
      evt_ready = 1'b0;
      onehot = 16'h0080;
      q.push_back({1'b0, 4'd3});
      q.push_back({1'b1, 4'd7});
      tick(8);
      chk("mrst_pre_valid", {31'd0, evt_valid}, 32'd1);
      chk("mrst_pre_code",  {28'd0, code},      32'd7);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid",      {31'd0, evt_valid},  32'd0);
      chk("mrst_code_valid", {31'd0, code_valid}, 32'd0);
      q.delete();
      tick(2);
      rst_n = 1'b1;
      q.push_back({1'b1, 4'd7});
      tick(5);
      chk("mrst_valid_e5", {31'd0, evt_valid}, 32'd0);
      tick(1);
      chk("mrst_valid_e6",  {31'd0, evt_valid}, 32'd1);
      chk("mrst_evt_code",  {28'd0, evt_code},  32'd7);
      chk("mrst_evt_press", {31'd0, evt_press}, 32'd1);
      evt_ready = 1'b1;
      tick(3);
      chk("mrst_drained", q.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
